alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//   Two-entry in-order FIFO between the ALU stage and the writeback stage.
//   A push takes one cycle to reach the head (no bypass). InReady depends
//   only on registered occupancy, so there is no combinational path from
//   OutReady to InReady. flush drops every buffered entry and takes
//   priority over any push or pop in the same cycle.
//
//   Optional feature macro: ALUBUF_FLAGS_EN
//     When defined, {Z,N,V,C} flags are stored with each entry and forwarded.
//     When undefined, the Flags/OutFlags ports and their storage are absent.
//
//   Ports
//     clk          clock, rising edge
//     reset_n      asynchronous active-low reset
//     flush        synchronous discard of all entries
//     InValid      upstream offers an entry
//     InReady      buffer can accept an entry (registered)
//     Result       ALU result            [WIDTH]
//     Rd           destination register  [RD_W]
//     RegWrite     writeback enable
//     Flags        {Z,N,V,C}             (ALUBUF_FLAGS_EN only)
//     OutValid     head entry valid
//     OutReady     writeback consumes the head entry
//     OutResult    head result           [WIDTH]
//     OutRd        head register index   [RD_W]
//     OutRegWrite  head writeback enable
//     OutFlags     head flags            (ALUBUF_FLAGS_EN only)
//     Count        occupied entries 0..2
// -----------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] Result,
  input  logic [RD_W-1:0]  Rd,
  input  logic             RegWrite,
`ifdef ALUBUF_FLAGS_EN
  input  logic [3:0]       Flags,
  output logic [3:0]       OutFlags,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutResult,
  output logic [RD_W-1:0]  OutRd,
  output logic             OutRegWrite,
  output logic [1:0]       Count
);

  // Occupancy and 1-bit wrap-around pointers.
  logic [1:0] count_r;
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       in_ready_r;
  logic       out_valid_r;

  logic [1:0] count_nxt_s;
  logic       wr_ptr_nxt_s;
  logic       rd_ptr_nxt_s;
  logic       push_s;
  logic       pop_s;

  // Entry storage.
  logic [WIDTH-1:0] result_mem_r   [2];
  logic [RD_W-1:0]  rd_mem_r       [2];
  logic             regwrite_mem_r [2];
`ifdef ALUBUF_FLAGS_EN
  logic [3:0]       flags_mem_r    [2];
`endif

  assign push_s = InValid && in_ready_r;
  assign pop_s  = out_valid_r && OutReady;

  // Next occupancy and pointers; flush overrides push and pop.
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (flush) begin
      count_nxt_s  = 2'd0;
      wr_ptr_nxt_s = 1'b0;
      rd_ptr_nxt_s = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = ~wr_ptr_r;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = ~rd_ptr_r;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + 2'd1;
        2'b01:   count_nxt_s = count_r - 2'd1;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state; InReady/OutValid are registered from the next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r     <= 2'd0;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
    end
  end

  // Entry write; the write pointer only ever addresses a free slot, so the
  // head is never overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        result_mem_r[i]   <= '0;
        rd_mem_r[i]       <= '0;
        regwrite_mem_r[i] <= 1'b0;
`ifdef ALUBUF_FLAGS_EN
        flags_mem_r[i]    <= 4'd0;
`endif
      end
    end else if (push_s && !flush) begin
      result_mem_r[wr_ptr_r]   <= Result;
      rd_mem_r[wr_ptr_r]       <= Rd;
      regwrite_mem_r[wr_ptr_r] <= RegWrite;
`ifdef ALUBUF_FLAGS_EN
      flags_mem_r[wr_ptr_r]    <= Flags;
`endif
    end
  end

  // Head read-out from registered state; forced to zero when empty.
  always_comb begin
    OutResult   = '0;
    OutRd       = '0;
    OutRegWrite = 1'b0;
`ifdef ALUBUF_FLAGS_EN
    OutFlags    = 4'd0;
`endif
    if (out_valid_r) begin
      OutResult   = result_mem_r[rd_ptr_r];
      OutRd       = rd_mem_r[rd_ptr_r];
      OutRegWrite = regwrite_mem_r[rd_ptr_r];
`ifdef ALUBUF_FLAGS_EN
      OutFlags    = flags_mem_r[rd_ptr_r];
`endif
    end else begin
      OutResult   = '0;
      OutRd       = '0;
      OutRegWrite = 1'b0;
`ifdef ALUBUF_FLAGS_EN
      OutFlags    = 4'd0;
`endif
    end
  end

  assign InReady  = in_ready_r;
  assign OutValid = out_valid_r;
  assign Count    = count_r;

endmodule
